// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop input sync, false-start rejection, framing/overrun
// detection, valid/ready output. Parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic                 dcom,
  output logic [DATA_BITS-1:0] bus,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] bus_q;
  logic                 stop_bad_q;
  logic                 armed_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 dcom_s;
  logic                 frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
  logic                 parity_err_q;
`endif

  assign dcom_s = sync_q[1];

  // Earlier stop bits accumulate into stop_bad_q; the final one is judged live.
  always_comb begin
    frame_bad = stop_bad_q | ~dcom_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      bus_q       <= '0;
      stop_bad_q  <= 1'b0;
      armed_q     <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], dcom};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (valid_q && ready) valid_q <= 1'b0;
      if (tick_in) begin
        if (dcom_s) armed_q <= 1'b1;
        case (state_q)
          IDLE: if (!dcom_s && armed_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
          START: if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (dcom_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
          DATA: if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {dcom_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`ifdef UART_RX_PARITY_EN
          PARITY: if (cnt_q == CNT_FULL) begin
            cnt_q     <= '0;
            state_q   <= STOP;
            par_bad_q <= dcom_s ^ (^shift_q) ^ ODD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
          STOP: if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            if (bit_q == LAST_STOP) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              bit_q      <= '0;
              stop_bad_q <= 1'b0;
              // Clearing armed here overrides the re-arm above, so a held-low line reports once.
              if (frame_bad) begin
                frame_err_q <= 1'b1;
                armed_q     <= 1'b0;
              end
`ifdef UART_RX_PARITY_EN
              else if (par_bad_q) begin
                parity_err_q <= 1'b1;
              end
`endif
              else if (!valid_q || ready) begin
                bus_q   <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + BW'(1);
              if (!dcom_s) stop_bad_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus       = bus_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0 & (PARITY_ODD != 0);
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8-bit words, 16x oversampling, tick every 4 clk; a second
// instance with two stop bits shares the line. Build with UART_RX_PARITY_EN for parity cases.
module tb_uart_rx_param;
  localparam int OS = 16;
  localparam logic ODD = 1'b0;

  logic clk = 1'b0, rst = 1'b1, tick_in = 1'b0, dcom = 1'b1, ready = 1'b0;
  logic [7:0] bus, bus2;
  logic valid, busy, frame_err, parity_err, overrun;
  logic valid2, busy2, frame_err2, parity_err2, overrun2;

  int passed = 0, total = 0, tick_no = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, fe2_cnt = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  logic [7:0] q1[$], q2[$];
  logic [7:0] w;
  bit ok;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .dcom(dcom), .bus(bus), .valid(valid),
    .ready(ready), .busy(busy), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .dcom(dcom), .bus(bus2), .valid(valid2),
    .ready(ready), .busy(busy2), .frame_err(frame_err2), .parity_err(parity_err2), .overrun(overrun2));

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) begin @(negedge clk); tick_in = 1'b0; end
      @(negedge clk); tick_in = 1'b1; tick_no++;
    end
  end

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err2 === 1'b1) fe2_cnt++;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  function automatic logic calc_par(input logic [7:0] d);
    return (^d) ^ ODD;
  endfunction

  task automatic wait_ticks(input int n);
    int t;
    t = tick_no + n;
    while (tick_no < t) @(negedge clk);
  endtask

  task automatic wait_valid(input bit second, output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((second ? valid2 : valid) === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ready();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s0,
                            input logic s1, input int nstop, input bit hold_low);
    logic [11:0] frm;
    int nb;
`ifdef UART_RX_PARITY_EN
    frm = {s1, s0, pbit, d, 1'b0};
    nb  = 11;
`else
    frm = {pbit, s1, s0, d, 1'b0};
    nb  = 10;
`endif
    if (nstop == 2) nb++;
    for (int i = 0; i < nb; i++) begin
      dcom = frm[i];
      wait_ticks(OS);
    end
    if (!hold_low) dcom = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus !== 8'h00) $display("FAIL reset_bus: got %h want 00", bus); else passed++;
    total++; if ({valid, busy, frame_err, parity_err, overrun} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {valid, busy, frame_err, parity_err, overrun}); else passed++;
    total++; if ({bus2, valid2, busy2} !== 10'b0)
      $display("FAIL reset_dut2: got %b want 0", {bus2, valid2, busy2}); else passed++;
    rst = 1'b0;
    wait_ticks(4);
    total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_basic();
    ready = 1'b0;
    q1.push_back(8'hA5);
    send_frame(8'hA5, calc_par(8'hA5), 1'b1, 1'b1, 1, 1'b0);
    wait_valid(1'b0, ok);
    w = q1.pop_front();
    total++; if (!ok || bus !== w) $display("FAIL basic_word: valid=%b bus=%h want valid=1 bus=%h", valid, bus, w); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else passed++;
    wait_ticks(20);
    total++; if (valid !== 1'b1 || bus !== w) $display("FAIL basic_hold: valid=%b bus=%h want 1 %h", valid, bus, w); else passed++;
    pulse_ready();
    total++; if (valid !== 1'b0) $display("FAIL basic_consume: valid=%b want 0", valid); else passed++;
    total++; if (fe_cnt !== exp_fe || ov_cnt !== exp_ov || pe_cnt !== exp_pe)
      $display("FAIL basic_pulses: fe/ov/pe=%0d/%0d/%0d want %0d/%0d/%0d", fe_cnt, ov_cnt, pe_cnt, exp_fe, exp_ov, exp_pe); else passed++;
  endtask

  task automatic test_false_start();
    dcom = 1'b0;
    wait_ticks(4);
    total++; if (busy !== 1'b1) $display("FAIL false_busy_high: got %b want 1", busy); else passed++;
    dcom = 1'b1;
    wait_ticks(8);
    total++; if (busy !== 1'b0) $display("FAIL false_busy_low: got %b want 0", busy); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL false_valid: got %b want 0", valid); else passed++;
    total++; if (fe_cnt !== exp_fe || ov_cnt !== exp_ov || pe_cnt !== exp_pe)
      $display("FAIL false_pulses: fe/ov/pe=%0d/%0d/%0d want %0d/%0d/%0d", fe_cnt, ov_cnt, pe_cnt, exp_fe, exp_ov, exp_pe); else passed++;
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    q1.push_back(8'h3C);
    send_frame(8'h3C, calc_par(8'h3C), 1'b1, 1'b1, 1, 1'b0);
    send_frame(8'hC3, calc_par(8'hC3), 1'b1, 1'b1, 1, 1'b0);
    exp_ov++;
    wait_valid(1'b0, ok);
    w = q1.pop_front();
    total++; if (!ok || bus !== w) $display("FAIL b2b_hold: valid=%b bus=%h want 1 %h", valid, bus, w); else passed++;
    total++; if (ov_cnt !== exp_ov) $display("FAIL b2b_overrun: count=%0d want %0d", ov_cnt, exp_ov); else passed++;
    pulse_ready();
    total++; if (valid !== 1'b0) $display("FAIL b2b_consume: valid=%b want 0", valid); else passed++;
    q1.push_back(8'h5A);
    send_frame(8'h5A, calc_par(8'h5A), 1'b1, 1'b1, 1, 1'b0);
    wait_valid(1'b0, ok);
    w = q1.pop_front();
    total++; if (!ok || bus !== w) $display("FAIL b2b_next: valid=%b bus=%h want 1 %h", valid, bus, w); else passed++;
    total++; if (ov_cnt !== exp_ov) $display("FAIL b2b_ov_once: count=%0d want %0d", ov_cnt, exp_ov); else passed++;
    pulse_ready();
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, calc_par(8'h55), 1'b0, 1'b0, 1, 1'b1);
    exp_fe++;
    wait_ticks(40);
    dcom = 1'b1;
    wait_ticks(20);
    total++; if (fe_cnt !== exp_fe) $display("FAIL fe_count: count=%0d want %0d", fe_cnt, exp_fe); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL fe_valid: got %b want 0", valid); else passed++;
    total++; if (ov_cnt !== exp_ov || pe_cnt !== exp_pe)
      $display("FAIL fe_other: ov/pe=%0d/%0d want %0d/%0d", ov_cnt, pe_cnt, exp_ov, exp_pe); else passed++;
    q1.push_back(8'h12);
    send_frame(8'h12, calc_par(8'h12), 1'b1, 1'b1, 1, 1'b0);
    wait_valid(1'b0, ok);
    w = q1.pop_front();
    total++; if (!ok || bus !== w) $display("FAIL fe_recover: valid=%b bus=%h want 1 %h", valid, bus, w); else passed++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    pulse_ready();
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    exp_pe++;
    wait_ticks(4);
    total++; if (pe_cnt !== exp_pe) $display("FAIL par_err_count: count=%0d want %0d", pe_cnt, exp_pe); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL par_bad_valid: got %b want 0", valid); else passed++;
    q1.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    wait_valid(1'b0, ok);
    w = q1.pop_front();
    total++; if (!ok || bus !== w) $display("FAIL par_good: valid=%b bus=%h want 1 %h", valid, bus, w); else passed++;
    total++; if (pe_cnt !== exp_pe || fe_cnt !== exp_fe)
      $display("FAIL par_good_pulses: pe/fe=%0d/%0d want %0d/%0d", pe_cnt, fe_cnt, exp_pe, exp_fe); else passed++;
  endtask
`endif

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h81;
    ready = 1'b0;
    dcom = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin dcom = d[i]; wait_ticks(OS); end
    dcom = d[4];
    wait_ticks(OS / 2);
    total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else passed++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++; if ({bus, valid, busy, frame_err, parity_err, overrun} !== 13'b0)
      $display("FAIL rstmid_outputs: got %b want 0", {bus, valid, busy, frame_err, parity_err, overrun}); else passed++;
    total++; if ({bus2, valid2, busy2} !== 10'b0)
      $display("FAIL rstmid_dut2: got %b want 0", {bus2, valid2, busy2}); else passed++;
    rst = 1'b0;
    dcom = 1'b1;
    wait_ticks(20);
    total++; if (fe_cnt !== exp_fe || ov_cnt !== exp_ov || pe_cnt !== exp_pe || busy !== 1'b0)
      $display("FAIL rstmid_quiet: fe/ov/pe=%0d/%0d/%0d busy=%b want %0d/%0d/%0d 0", fe_cnt, ov_cnt, pe_cnt, busy, exp_fe, exp_ov, exp_pe); else passed++;
    q1.push_back(8'h81);
    q2.push_back(8'h81);
    send_frame(8'h81, calc_par(8'h81), 1'b1, 1'b1, 1, 1'b0);
    wait_valid(1'b0, ok);
    w = q1.pop_front();
    total++; if (!ok || bus !== w) $display("FAIL rstmid_word: valid=%b bus=%h want 1 %h", valid, bus, w); else passed++;
    wait_ticks(12);
    wait_valid(1'b1, ok);
    w = q2.pop_front();
    total++; if (!ok || bus2 !== w) $display("FAIL rstmid_word2: valid2=%b bus2=%h want 1 %h", valid2, bus2, w); else passed++;
  endtask

  task automatic test_two_stop();
    int s;
    pulse_ready();
    s = fe2_cnt;
    send_frame(8'h3E, calc_par(8'h3E), 1'b0, 1'b1, 2, 1'b0);
    exp_fe++;
    wait_ticks(4);
    total++; if (fe2_cnt !== s + 1) $display("FAIL two_stop_first_bad: count=%0d want %0d", fe2_cnt, s + 1); else passed++;
    total++; if (valid2 !== 1'b0 || valid !== 1'b0) $display("FAIL two_stop_no_word: valid/valid2=%b%b want 00", valid, valid2); else passed++;
    total++; if (fe_cnt !== exp_fe) $display("FAIL two_stop_fe1: count=%0d want %0d", fe_cnt, exp_fe); else passed++;
    q1.push_back(8'hE7);
    q2.push_back(8'hE7);
    send_frame(8'hE7, calc_par(8'hE7), 1'b1, 1'b1, 2, 1'b0);
    wait_valid(1'b1, ok);
    w = q2.pop_front();
    total++; if (!ok || bus2 !== w) $display("FAIL two_stop_word2: valid2=%b bus2=%h want 1 %h", valid2, bus2, w); else passed++;
    wait_valid(1'b0, ok);
    w = q1.pop_front();
    total++; if (!ok || bus !== w) $display("FAIL two_stop_word1: valid=%b bus=%h want 1 %h", valid, bus, w); else passed++;
    total++; if (fe2_cnt !== s + 1 || ov_cnt !== exp_ov)
      $display("FAIL two_stop_pulses: fe2/ov=%0d/%0d want %0d/%0d", fe2_cnt, ov_cnt, s + 1, exp_ov); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_back_to_back();
    test_frame_err();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    test_two_stop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised oversampling UART receiver, next generation of the team's serial receive path. Takes the asynchronous serial line `dcom` and a baud-rate oversampling strobe `tick_in`, and recovers frames with configurable data width, oversampling ratio and stop-bit count. Words are presented on `bus` with a valid/ready handshake. Adds input synchronisation, false-start rejection, framing and overrun detection, and optional parity checking.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, 16: `tick_in` strobes per bit period; even, at least 4.
- `STOP_BITS`, 1: stop bits checked; 1 or 2.
- `PARITY_ODD`, 0: parity sense when parity is compiled in; 0 selects even parity, 1 selects odd parity.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `tick_in`  in  1  one-`clk`-wide strobe at OVERSAMPLE × baud.
- `dcom`  in  1  serial line; asynchronous; idles high.
- `bus`  out  DATA_BITS  received word, LSB first on the line.
- `valid`  out  1  `bus` holds an unconsumed word.
- `ready`  in  1  consumer accepts `bus` when `valid && ready`.
- `busy`  out  1  FSM is not in IDLE.
- `frame_err`  out  1  one-`clk` pulse: stop bit sampled low.
- `parity_err`  out  1  one-`clk` pulse: parity mismatch. Tied 0 when parity is compiled out.
- `overrun`  out  1  one-`clk` pulse: word completed while the holding register was full.

## Operation
- **Synchroniser.** `dcom` passes through a 2-flop synchroniser to form `dcom_s`. Both flops reset to 1. All sampling uses `dcom_s`. FSM state advances only on `clk` edges where `tick_in` = 1.
- **Tick counter.** Width is $clog2(OVERSAMPLE).
- **IDLE → START.** Taken when `dcom_s` = 0 on a tick and `armed` = 1. The tick counter clears.
- **START.** After OVERSAMPLE/2 ticks, sample the line (mid-start):
  - 0 → DATA.
  - 1 → IDLE (false start). No output pulses.
- **DATA.** Sample every OVERSAMPLE ticks and shift into the shift register, LSB first. After DATA_BITS samples, go to PARITY if parity is compiled in, otherwise STOP.
- **PARITY.** One sample after OVERSAMPLE ticks. Compare with the XOR of the data bits, XORed with PARITY_ODD. Result is latched; then go to STOP.
- **STOP.** STOP_BITS samples, OVERSAMPLE ticks apart. Any 0 means a framing error.
- **Completion** happens on the final stop sample; the FSM returns to IDLE on the same edge.
  - Frame error → `frame_err` pulses, word discarded, `armed` cleared.
  - Parity error (checked only if no frame error) → `parity_err` pulses, word discarded.
  - Good word with `valid` = 0, or `valid && ready` in the same cycle → `bus` ← shift register, `valid` = 1.
  - Good word with `valid` = 1 and `ready` = 0 → word dropped, `bus` unchanged, `overrun` pulses.
- **Re-arm.** `armed` is set when `dcom_s` = 1 on any tick. A line held low (break) therefore yields exactly one `frame_err` and no further frames until the line returns high.
- **Handshake.** `valid` clears on the edge where `valid && ready`, unless a new word loads on that same edge, in which case it stays 1. `bus` is stable while `valid` = 1.
- **Reset values.** All outputs are 0. State = IDLE, counters = 0, shift register = 0, `armed` = 1, synchroniser = 1. Reset mid-frame abandons the frame with no error pulses.
- `tick_in` is ignored outside the conditions above; `clk` cycles without a tick hold all state.

## Timing
- Start detected at tick T0.
- Mid-start sample at T0 + OVERSAMPLE/2.
- Data bit i (0-based) sampled at T0 + OVERSAMPLE/2 + (i+1)·OVERSAMPLE.
- Parity sampled at T0 + OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE.
- Stop bit k (0-based) sampled at T0 + OVERSAMPLE/2 + (DATA_BITS+1+P+k)·OVERSAMPLE, where P = 1 if parity is compiled in, otherwise 0.
- `valid`, `bus` and the error pulses register on the `clk` edge of the final stop-sample tick, and are visible in the following cycle.
- Input latency: 2 `clk` (synchroniser), plus up to 1 tick of start-detection jitter.
- Back-to-back frames are supported: a new start can be detected on the first tick after completion.
- `busy` is high from the START entry edge through the final stop-sample edge.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** the PARITY state exists, the frame carries one parity bit after the data, `PARITY_ODD` is honoured, and `parity_err` is driven.
- **Undefined:** no PARITY state, and the frame goes straight from DATA to STOP. `PARITY_ODD` is ignored and `parity_err` is constant 0.

## Test plan
Defaults unless stated: DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1; `tick_in` every 4 `clk`.
1. Send 0xA5 (8N1), `ready` = 0 → `bus` = 0xA5 and `valid` = 1, held. Then pulse `ready` → `valid` = 0 next cycle; `busy` low after the stop sample.
2. Drive `dcom` low for 4 ticks, then high → no `valid`, no error pulses; `busy` returns to 0 at the mid-start sample.
3. Send 0x3C then 0xC3 back-to-back with `ready` = 0 → `bus` = 0x3C and one `overrun` pulse. Then `ready` = 1 → 0x3C consumed; the next frame 0x5A is received normally.
4. Send 0x55 with the stop bit 0, then hold the line low 40 ticks, then high → exactly one `frame_err`, no `valid`. A subsequent 0x12 is received correctly.
5. With `UART_RX_PARITY_EN` defined and PARITY_ODD=0, send 0x07:
   - parity bit 0 → one `parity_err`, no `valid`;
   - parity bit 1 → `bus` = 0x07, `valid` = 1.
6. Assert `rst` for 1 `clk` during data bit 4 → all outputs 0 next cycle. A following frame 0x81 is received correctly; STOP_BITS=2 variant also passes.
